exotiny_ccx_link: RTL and testbench

Parametrised bridge between the core's 32-bit custom-instruction (CCX) request and a narrow off-chip accelerator pin interface. It serialises both operands chunk-wise onto `CHUNKSIZE`-wide output pins with a selectable accelerator channel. It then waits for the external response handshake, deserialises the result and returns it to the core. A watchdog aborts the request with an error flag if the accelerator never responds, and a synchronous input stage isolates the external pins.

---
 rtl/exotiny_ccx_link.sv | 160 ++++++++++++++++
 tb/tb_exotiny_ccx_link.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exotiny_ccx_link.sv
// exotiny_ccx_link
// Bridges a 32-bit custom-instruction request from the core to a narrow
// off-chip accelerator. Operands go out LSB-chunk first on CHUNKSIZE-wide
// pins. The result comes back the same way after the accelerator's response
// strobe. A watchdog ends a request with an error flag if no response arrives.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   ccx_valid_i          core request, held until ccx_ready_o
//   ccx_sel_i[SELW]      accelerator channel
//   ccx_rs_a_i/b_i[32]   operands
//   ccx_ready_o          one-cycle completion pulse
//   ccx_res_o[32]        result (valid with ready, held until next accept)
//   ccx_err_o            watchdog abort flag (valid with ready)
//   pin_rs_a_o/b_o[CS]   operand chunk pins
//   pin_sel_o[SELW]      channel pins, stable over a transaction
//   pin_req_o            high while operand chunks are driven
//   pin_res_i[CS]        result chunk pins
//   pin_resp_i           accelerator response strobe
module exotiny_ccx_link #(
  parameter int CHUNKSIZE = 4,
  parameter int SELW      = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ccx_valid_i,
  input  logic [SELW-1:0]      ccx_sel_i,
  input  logic [31:0]          ccx_rs_a_i,
  input  logic [31:0]          ccx_rs_b_i,
  output logic                 ccx_ready_o,
  output logic [31:0]          ccx_res_o,
  output logic                 ccx_err_o,
  output logic [CHUNKSIZE-1:0] pin_rs_a_o,
  output logic [CHUNKSIZE-1:0] pin_rs_b_o,
  output logic [SELW-1:0]      pin_sel_o,
  output logic                 pin_req_o,
  input  logic [CHUNKSIZE-1:0] pin_res_i,
  input  logic                 pin_resp_i
);

  localparam int N  = 32 / CHUNKSIZE;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
  // Last WAIT cycle count before the watchdog fires.
  localparam logic [CW-1:0] LAST_WAIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          beat_q;
  logic [CW-1:0]          wd_q;
  logic [31:0]            a_sh_q, b_sh_q, res_acc_q, res_merge;
  logic [4:0]             res_base;
  logic                   resp_q;
  logic [CHUNKSIZE-1:0]   res_q;
  logic                   timeout_hit;

  // Accumulated result with the chunk currently in res_q dropped into its slot.
  always_comb begin
    res_base  = 5'(int'(beat_q) * CHUNKSIZE);
    res_merge = res_acc_q;
    res_merge[res_base +: CHUNKSIZE] = res_q;
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: if (ccx_valid_i) state_d = S_SEND;
      S_SEND: if (beat_q == LAST_BEAT) state_d = S_WAIT;
      S_WAIT: begin
        // A response landing on the watchdog's final cycle still wins.
        if (resp_q) state_d = (N == 1) ? S_DONE : S_RECV;
        else if (TIMEOUT != 0 && wd_q == LAST_WAIT) begin
          timeout_hit = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_RECV: if (beat_q == LAST_BEAT) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      resp_q      <= 1'b0;
      res_q       <= '0;
      beat_q      <= '0;
      wd_q        <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_acc_q   <= '0;
      ccx_ready_o <= 1'b0;
      ccx_res_o   <= '0;
      ccx_err_o   <= 1'b0;
      pin_rs_a_o  <= '0;
      pin_rs_b_o  <= '0;
      pin_sel_o   <= '0;
      pin_req_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Strobe and data are registered together so they stay aligned.
      resp_q      <= pin_resp_i;
      res_q       <= pin_res_i;
      ccx_ready_o <= (state_d == S_DONE);
      pin_req_o   <= (state_d == S_SEND);
      pin_rs_a_o  <= '0;
      pin_rs_b_o  <= '0;
      case (state_q)
        S_IDLE: if (ccx_valid_i) begin
          pin_sel_o  <= ccx_sel_i;
          pin_rs_a_o <= ccx_rs_a_i[CHUNKSIZE-1:0];
          pin_rs_b_o <= ccx_rs_b_i[CHUNKSIZE-1:0];
          a_sh_q     <= ccx_rs_a_i >> CHUNKSIZE;
          b_sh_q     <= ccx_rs_b_i >> CHUNKSIZE;
          beat_q     <= '0;
          res_acc_q  <= '0;
          ccx_res_o  <= '0;
          ccx_err_o  <= 1'b0;
        end
        S_SEND: begin
          if (state_d == S_SEND) begin
            pin_rs_a_o <= a_sh_q[CHUNKSIZE-1:0];
            pin_rs_b_o <= b_sh_q[CHUNKSIZE-1:0];
            a_sh_q     <= a_sh_q >> CHUNKSIZE;
            b_sh_q     <= b_sh_q >> CHUNKSIZE;
            beat_q     <= beat_q + 1'b1;
          end else begin
            beat_q <= '0;
            wd_q   <= '0;
          end
        end
        S_WAIT: begin
          if (resp_q) begin
            res_acc_q <= res_merge;
            if (N > 1) beat_q <= beat_q + 1'b1;
          end else if (TIMEOUT != 0) begin
            wd_q <= wd_q + 1'b1;
          end
          if (state_d == S_DONE) begin
            ccx_res_o <= timeout_hit ? '0 : res_merge;
            ccx_err_o <= timeout_hit;
          end
        end
        S_RECV: begin
          res_acc_q <= res_merge;
          beat_q    <= beat_q + 1'b1;
          if (state_d == S_DONE) ccx_res_o <= res_merge;
        end
        S_DONE: pin_sel_o <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exotiny_ccx_link.sv
// Directed bench for exotiny_ccx_link: a CHUNKSIZE=4 / TIMEOUT=16 instance
// driven by a behavioural accelerator, plus CHUNKSIZE=8 and 32 instances
// exercised with an immediate response.
module tb_exotiny_ccx_link;
  logic clk, rst;
  int checks = 0, failures = 0;

  // CHUNKSIZE=4 instance
  logic        ccx_valid, ccx_ready, ccx_err, pin_req, pin_resp;
  logic [1:0]  ccx_sel, pin_sel;
  logic [31:0] ccx_a, ccx_b, ccx_res;
  logic [3:0]  pin_a, pin_b, pin_res;

  // CHUNKSIZE=8 instance
  logic        v8, rdy8, err8, req8, resp8;
  logic [1:0]  sel8;
  logic [31:0] a8, b8, res8;
  logic [7:0]  pa8, pb8, pres8;

  // CHUNKSIZE=32 instance
  logic        v32, rdy32, err32, req32, resp32;
  logic [1:0]  sel32;
  logic [31:0] a32, b32, res32, pa32, pb32, pres32;

  exotiny_ccx_link #(.CHUNKSIZE(4), .SELW(2), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .ccx_valid_i(ccx_valid), .ccx_sel_i(ccx_sel),
    .ccx_rs_a_i(ccx_a), .ccx_rs_b_i(ccx_b), .ccx_ready_o(ccx_ready),
    .ccx_res_o(ccx_res), .ccx_err_o(ccx_err), .pin_rs_a_o(pin_a),
    .pin_rs_b_o(pin_b), .pin_sel_o(pin_sel), .pin_req_o(pin_req),
    .pin_res_i(pin_res), .pin_resp_i(pin_resp));

  exotiny_ccx_link #(.CHUNKSIZE(8), .SELW(2), .TIMEOUT(16)) dut8 (
    .clk_i(clk), .rst_i(rst), .ccx_valid_i(v8), .ccx_sel_i(2'd2),
    .ccx_rs_a_i(a8), .ccx_rs_b_i(b8), .ccx_ready_o(rdy8),
    .ccx_res_o(res8), .ccx_err_o(err8), .pin_rs_a_o(pa8),
    .pin_rs_b_o(pb8), .pin_sel_o(sel8), .pin_req_o(req8),
    .pin_res_i(pres8), .pin_resp_i(resp8));

  exotiny_ccx_link #(.CHUNKSIZE(32), .SELW(2), .TIMEOUT(16)) dut32 (
    .clk_i(clk), .rst_i(rst), .ccx_valid_i(v32), .ccx_sel_i(2'd3),
    .ccx_rs_a_i(a32), .ccx_rs_b_i(b32), .ccx_ready_o(rdy32),
    .ccx_res_o(res32), .ccx_err_o(err32), .pin_rs_a_o(pa32),
    .pin_rs_b_o(pb32), .pin_sel_o(sel32), .pin_req_o(req32),
    .pin_res_i(pres32), .pin_resp_i(resp32));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural accelerator for the CHUNKSIZE=4 instance. Answers rsp_delay
  // cycles after pin_req falls, one chunk per cycle, strobe on chunk 0 only.
  logic [31:0] rsp_word;
  int          rsp_delay;
  bit          respond_en, send_pulse;
  logic        prev_req;

  initial begin
    pin_resp = 1'b0; pin_res = '0; prev_req = 1'b0;
    forever begin
      @(negedge clk);
      // Optional spurious strobe on the first SEND cycle.
      pin_resp = send_pulse && pin_req && !prev_req;
      if (prev_req && !pin_req && respond_en) begin
        repeat (rsp_delay) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          pin_resp = (k == 0);
          pin_res  = rsp_word[4*k +: 4];
          @(negedge clk);
        end
        pin_resp = 1'b0;
        pin_res  = '0;
      end
      prev_req = pin_req;
    end
  end

  // Snapshot of one transaction on the CHUNKSIZE=4 instance.
  int          lat, nreq, late_req;
  logic [31:0] seq_a, seq_b, got_res;
  logic        got_err;
  logic [1:0]  got_sel;

  task automatic run_txn(input logic [31:0] av, input logic [31:0] bv,
                         input logic [1:0] sv, input int rst_at);
    int spurious;
    repeat (2) @(negedge clk);
    ccx_valid = 1'b1; ccx_a = av; ccx_b = bv; ccx_sel = sv;
    lat = 0; nreq = 0; late_req = 0; seq_a = '0; seq_b = '0;
    while (lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (pin_req) begin
        if (nreq < 8) begin
          seq_a[4*nreq +: 4] = pin_a;
          seq_b[4*nreq +: 4] = pin_b;
        end
        nreq++;
        if (lat > 8) late_req++;
      end
      if (rst_at != 0 && lat == rst_at) begin
        ccx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", ccx_ready, 0);
        chk("rst_req",   pin_req, 0);
        chk("rst_sel",   pin_sel, 0);
        chk("rst_res",   ccx_res, 0);
        chk("rst_err",   ccx_err, 0);
        spurious = 0;
        repeat (20) begin
          @(negedge clk);
          if (ccx_ready) spurious++;
        end
        chk("rst_no_ready", spurious, 0);
        return;
      end
      if (ccx_ready) break;
    end
    chk("txn_bound", ccx_ready, 1);
    got_res = ccx_res; got_err = ccx_err; got_sel = pin_sel;
    ccx_valid = 1'b0;
    @(negedge clk);
    chk("ready_pulse", ccx_ready, 0);
    chk("sel_idle", pin_sel, 0);
    chk("res_hold", ccx_res, got_res);
  endtask

  // Both wide instances run side by side; the bench answers at w directly.
  task automatic run_wide(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] w);
    int l;
    bit d8, d32;
    logic [31:0] wv;
    l = 0; d8 = 0; d32 = 0; wv = w;
    repeat (2) @(negedge clk);
    v8 = 1'b1; v32 = 1'b1; a8 = av; b8 = bv; a32 = av; b32 = bv;
    while (l < 40 && !(d8 && d32)) begin
      @(posedge clk); l++;
      @(negedge clk);
      if (rdy8 && !d8) begin
        d8 = 1; v8 = 1'b0;
        chk("w8_lat", l, 10); chk("w8_res", res8, wv); chk("w8_err", err8, 0);
      end
      if (rdy32 && !d32) begin
        d32 = 1; v32 = 1'b0;
        chk("w32_lat", l, 4); chk("w32_res", res32, wv); chk("w32_err", err32, 0);
      end
      if (l == 1) begin
        chk("w8_a0", pa8, av[7:0]);
        chk("w32_a0", pa32, av);
      end
      resp8  = (l == 5);
      pres8  = (l >= 5 && l <= 8) ? wv[8*(l-5) +: 8] : 8'h00;
      resp32 = (l == 2);
      pres32 = (l == 2) ? wv : 32'h0;
    end
    chk("w8_done", d8, 1);
    chk("w32_done", d32, 1);
  endtask

  initial begin
    rst = 1'b1;
    ccx_valid = 1'b0; ccx_a = '0; ccx_b = '0; ccx_sel = '0;
    v8 = 1'b0; a8 = '0; b8 = '0; resp8 = 1'b0; pres8 = '0;
    v32 = 1'b0; a32 = '0; b32 = '0; resp32 = 1'b0; pres32 = '0;
    rsp_word = '0; rsp_delay = 0; respond_en = 1'b1; send_pulse = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ready", ccx_ready, 0);
    chk("reset_res",   ccx_res, 0);
    chk("reset_err",   ccx_err, 0);
    chk("reset_req",   pin_req, 0);
    chk("reset_sel",   pin_sel, 0);
    chk("reset_pin_a", pin_a, 0);
    rst = 1'b0;

    // Basic transaction, immediate response.
    rsp_word = 32'hCAFEBABE;
    run_txn(32'h12345678, 32'h9ABCDEF0, 2'd1, 0);
    chk("t1_lat",   lat, 18);
    chk("t1_res",   got_res, 32'hCAFEBABE);
    chk("t1_err",   got_err, 0);
    chk("t1_seq_a", seq_a, 32'h12345678);
    chk("t1_seq_b", seq_b, 32'h9ABCDEF0);
    chk("t1_nreq",  nreq, 8);
    chk("t1_sel",   got_sel, 1);

    // Response delayed by 10 cycles.
    rsp_word = 32'h0F1E2D3C; rsp_delay = 10;
    run_txn(32'hA5A5A5A5, 32'h00000001, 2'd2, 0);
    chk("t2_lat",      lat, 28);
    chk("t2_res",      got_res, 32'h0F1E2D3C);
    chk("t2_late_req", late_req, 0);
    chk("t2_sel",      got_sel, 2);

    // No response: watchdog fires.
    respond_en = 1'b0;
    run_txn(32'hFFFFFFFF, 32'h0, 2'd3, 0);
    chk("t3_lat", lat, 25);
    chk("t3_err", got_err, 1);
    chk("t3_res", got_res, 0);

    // Next request completes cleanly.
    respond_en = 1'b1; rsp_delay = 0; rsp_word = 32'h13579BDF;
    run_txn(32'h1, 32'h2, 2'd0, 0);
    chk("t3b_lat", lat, 18);
    chk("t3b_err", got_err, 0);
    chk("t3b_res", got_res, 32'h13579BDF);

    // Strobe during SEND is ignored; real response at w+3.
    send_pulse = 1'b1; rsp_delay = 3; rsp_word = 32'h8badf00d;
    run_txn(32'h11112222, 32'h33334444, 2'd1, 0);
    send_pulse = 1'b0;
    chk("t4_lat", lat, 21);
    chk("t4_res", got_res, 32'h8badf00d);

    // Reset during RECV, then a fresh request.
    rsp_delay = 0; rsp_word = 32'hDEADDEAD;
    run_txn(32'h5, 32'h6, 2'd1, 12);
    rsp_word = 32'h2468ACE0;
    run_txn(32'h7, 32'h8, 2'd2, 0);
    chk("t5_lat", lat, 18);
    chk("t5_res", got_res, 32'h2468ACE0);
    chk("t5_err", got_err, 0);

    // Wider chunk builds.
    run_wide(32'hC001D00D, 32'h0BADBEEF, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
